mux_select_arbiter: RTL
=======================

Name: mux_select_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource between up to 8 requesters.
- Drives the one-hot select input of the generic one-hot priority Mux used across the SoC, so that exactly one requester's data reaches the shared resource at a time.
- Sits between requester cores and a shared bus or peripheral port.
- Grants are registered and glitch-free, with a guaranteed dead cycle between owners and an optional per-grant transfer limit.

Parameters:
- INPUTS, 4, number of requesters; legal range 1..8, matching the Mux's supported range.
- MAX_HOLD, 0, transfers allowed per grant before forced re-arbitration; 0 = unlimited.
- HOLD_WIDTH, 8, width of the transfer counter; MAX_HOLD must fit in HOLD_WIDTH bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- request  input  INPUTS  request[i] high while requester i wants the resource; held until it has finished.
- transferDone  input  1  one-cycle pulse from the shared resource marking one completed transfer (e.g. bus ack).
- select  output  INPUTS  registered one-hot grant; connects directly to the Mux select.
- busy  output  1  high while any grant is active; equals |select.
- grantIndex  output  3  binary index of the granted requester; 0 when not busy.

Behaviour:
- Reset: one clock, synchronous active-high; synchronous reset on rst high at a clock edge.
  - select=0, busy=0, grantIndex=0.
  - Round-robin pointer=0, holdCount=0, state=IDLE.
- States:
  - IDLE
    - If any request bit is set, pick the first set bit scanning from pointer upward with wrap-around modulo INPUTS.
    - At the next edge: select gets that one-hot bit, grantIndex gets its index, holdCount=0, state goes to GRANT.
    - Latency: request seen high in cycle N gives select valid from edge N+1.
    - With no requests, stay in IDLE with select=0.
  - GRANT
    - select, grantIndex and busy hold constant.
    - Each transferDone pulse increments holdCount; the counter saturates at its maximum.
    - Release when request[grantIndex] is low at an edge.
    - Forced release when MAX_HOLD != 0, this transferDone brings the count to MAX_HOLD, and another request bit is set.
    - On release, at that edge: select=0, busy=0, grantIndex=0, pointer=(grantIndex+1) mod INPUTS, state goes to IDLE.
- Dead cycle:
  - After any release, select is all-zero for at least one full cycle before the next grant.
  - The Mux therefore outputs DEFAULT and outputEnable=0 between owners.
- Forced limit with no other requester pending: keep the grant and clear holdCount to 0.
- Simultaneous events:
  - Request drop and transferDone on the same edge: the transfer is counted and the grant is released; release is a single event.
  - transferDone while in IDLE is ignored.
  - A request asserting in the release cycle is considered at the following IDLE edge.
  - The just-released requester becomes lowest priority for the next grant.
- select must never have more than one bit set, under any input sequence.
- rst asserted mid-grant: outputs return to reset values at that edge; any in-flight transfer is abandoned (the owner handles it).
- INPUTS=1: pointer stays 0; grant/release behave as above with the dead cycle.
- Changes to request bits other than the granted one have no effect during GRANT.

Test Plan:
- Reset, then INPUTS=4, request=4'b0100 at cycle 2 -> select=4'b0100 and grantIndex=2 from cycle 3; request low at cycle 6 -> select=0 from cycle 7.
- request=4'b1111 held, each owner drops its request after 1 transferDone and re-raises it -> grant order 0,1,2,3,0 with exactly one zero-select cycle between grants.
- MAX_HOLD=3, request=4'b0011, owner 0 never drops -> after the 3rd transferDone select=0 for 1 cycle, then 4'b0010; repeat with only request[0] set -> grant kept, holdCount back to 0.
- Owner 1 drops its request on the same edge as transferDone -> single release, pointer=2, no double grant.
- rst pulsed while select=4'b1000 -> select=0, busy=0 next edge; with request=4'b1001 held, the next grant is index 0.
- Random request/transferDone traffic for 10k cycles -> assert select is one-hot or zero every cycle, busy==|select, and no requester starves beyond INPUTS grants.

Source files
------------

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter driving the one-hot select of the shared priority Mux.
// Grants are registered. There is always one idle cycle between owners.
// An optional per-grant transfer limit forces re-arbitration when others wait.
module mux_select_arbiter #(
    parameter int INPUTS     = 4,
    parameter int MAX_HOLD   = 0,
    parameter int HOLD_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INPUTS-1:0] request,
    input  logic              transferDone,
    output logic [INPUTS-1:0] select,
    output logic              busy,
    output logic [2:0]        grantIndex
);

    typedef enum logic {
        IDLE,
        GRANT
    } stateT;

    localparam logic [2:0]            LAST_INDEX = 3'(INPUTS - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_LIMIT = HOLD_WIDTH'(MAX_HOLD);
    localparam logic [HOLD_WIDTH-1:0] HOLD_MAX   = '1;

    stateT                 state;
    stateT                 stateNext;
    logic [INPUTS-1:0]     selectNext;
    logic [2:0]            grantIndexNext;
    logic [2:0]            pointer;
    logic [2:0]            pointerNext;
    logic [HOLD_WIDTH-1:0] holdCount;
    logic [HOLD_WIDTH-1:0] holdCountNext;
    logic [HOLD_WIDTH-1:0] countBumped;
    logic [2:0]            pick;
    logic                  found;
    logic                  ownerRequest;
    logic                  othersRequest;
    logic                  limitHit;

    // The select register is one-hot or zero, so busy is just its OR.
    assign busy = |select;

    // The owner's request bit and the requests from everyone else are taken from the current one-hot select.
    assign ownerRequest  = |(request & select);
    assign othersRequest = |(request & ~select);

    // The transfer counter saturates. The limit only applies when a nonzero MAX_HOLD is configured.
    assign countBumped = (transferDone && (holdCount != HOLD_MAX)) ? holdCount + 1'b1 : holdCount;
    assign limitHit    = (MAX_HOLD != 0) && transferDone && (countBumped == HOLD_LIMIT);

    // Find the first requester at or above the pointer, wrapping around to the lowest index below the pointer.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = INPUTS - 1; i >= 0; i--) begin
            if (request[i] && (i < int'(pointer))) begin
                pick  = 3'(i);
                found = 1'b1;
            end
        end
        for (int i = INPUTS - 1; i >= 0; i--) begin
            if (request[i] && (i >= int'(pointer))) begin
                pick  = 3'(i);
                found = 1'b1;
            end
        end
    end

    // Next-state logic: grant from IDLE, release or hold in GRANT.
    always_comb begin
        stateNext      = state;
        selectNext     = select;
        grantIndexNext = grantIndex;
        pointerNext    = pointer;
        holdCountNext  = holdCount;
        case (state)
            IDLE: begin
                selectNext = '0;
                if (found) begin
                    selectNext     = INPUTS'(1) << pick;
                    grantIndexNext = pick;
                    holdCountNext  = '0;
                    stateNext      = GRANT;
                end
            end
            GRANT: begin
                if (!ownerRequest || (limitHit && othersRequest)) begin
                    selectNext     = '0;
                    grantIndexNext = '0;
                    pointerNext    = (grantIndex == LAST_INDEX) ? 3'd0 : grantIndex + 3'd1;
                    holdCountNext  = '0;
                    stateNext      = IDLE;
                end else if (limitHit) begin
                    holdCountNext = '0;
                end else begin
                    holdCountNext = countBumped;
                end
            end
            default: begin
                selectNext     = '0;
                grantIndexNext = '0;
                stateNext      = IDLE;
            end
        endcase
    end

    // State, grant and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            select     <= '0;
            grantIndex <= '0;
            pointer    <= '0;
            holdCount  <= '0;
        end else begin
            state      <= stateNext;
            select     <= selectNext;
            grantIndex <= grantIndexNext;
            pointer    <= pointerNext;
            holdCount  <= holdCountNext;
        end
    end

endmodule
